id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Pipeline register between decode and execute in the 5-stage MIPS pipeline.
- Captures the register-file read operands, immediate, register indices and control bits for the instruction in decode.
- Includes load-use hazard detection, which stalls upstream and inserts a bubble, and a branch flush.
- Bypasses a write-back that lands on the same edge as the capture, because the register file's negedge read is stale at that edge.
- Keeps saturating stall and flush event counters.

Parameters:
- CNT_W, 16, width of the stall_count and flush_count event counters.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset, sampled on posedge clk.
- id_valid  in  1  decode holds a real instruction.
- id_pc  in  32  PC+4 of the decode instruction.
- id_read_data1  in  32  rs operand from the register file.
- id_read_data2  in  32  rt operand from the register file.
- id_imm  in  32  sign-extended immediate.
- id_rs, id_rt, id_rd  in  5 each  register indices.
- id_uses_rt  in  1  instruction reads rt as a source (R-type, store, branch).
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst  in  1 each  decoded control.
- id_alu_op  in  4  ALU operation.
- wb_reg_write  in  1  write-back is writing the register file this cycle.
- wb_write_reg  in  5  write-back destination.
- wb_write_data  in  32  write-back data.
- flush  in  1  taken branch/jump resolved in EX; kill the decode instruction.
- stall_out  out  1  hold PC and IF/ID (combinational).
- ex_valid  out  1  EX holds a real instruction.
- ex_pc, ex_read_data1, ex_read_data2, ex_imm  out  32 each  registered copies.
- ex_rs, ex_rt, ex_rd  out  5 each  registered copies.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst  out  1 each  registered control.
- ex_alu_op  out  4  registered ALU operation.
- stall_count  out  CNT_W  number of stall cycles.
- flush_count  out  CNT_W  number of flush cycles.

Behaviour:
- Reset (rst=0 at posedge): every registered output goes to 0, including the valid bit, all control bits, data, indices and both counters.
  - stall_out is combinational and is 0 during reset.
- hazard = id_valid & ex_valid & ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
- stall_out = hazard & ~flush & rst.
- Per-posedge priority: reset > flush > hazard > load.
  - flush=1: load a bubble (ex_valid=0, all control outputs 0; data/index fields don't-care, clear to 0). flush_count increments.
  - hazard=1 and flush=0: load a bubble; stall_count increments. Upstream holds, so the same instruction reappears next cycle.
    - The bubble clears ex_mem_read, so the stall lasts exactly 1 cycle per load-use pair.
  - Otherwise: load all id_* fields. ex_valid = id_valid. Control bits are gated to 0 when id_valid=0.
- Write-back bypass, applied on load only:
  - If wb_reg_write & wb_write_reg != 0 & wb_write_reg == id_rs, then ex_read_data1 = wb_write_data.
  - Same rule for id_rt and ex_read_data2.
  - Both operands bypass independently when both match.
  - Register 0 is never bypassed.
- Counters saturate at all-ones and do not wrap.
- Latency: 1 cycle from decode to EX outputs.
- No other state; no handshake beyond stall_out and flush.

Test Plan:
- Reset: assert rst=0 for 2 cycles with non-zero id inputs -> all ex_* outputs, ex_valid and both counters are 0; stall_out=0.
- Plain load: id_valid=1, id_read_data1=0x11, id_read_data2=0x22, id_imm=0xFFFFFFF0, id_rs=1, id_rt=2, id_rd=3, id_reg_write=1, id_alu_op=2 -> next posedge ex_* equal these values and ex_valid=1.
- Load-use: EX holds lw with ex_rt=5, ex_mem_read=1; decode add with id_rs=5 -> stall_out=1 for exactly one cycle, EX receives a bubble (ex_valid=0, ex_reg_write=0), stall_count=1; the add enters EX the following cycle.
  - Repeat with ex_rt=0 or id_uses_rt=0 matching rt only -> no stall.
- Flush vs. hazard: flush=1 in the same cycle as a load-use hazard -> stall_out=0, bubble loaded, flush_count=1, stall_count unchanged.
- WB bypass: id_rs=id_rt=7, id_read_data1=id_read_data2=0xAAAA, wb_reg_write=1, wb_write_reg=7, wb_write_data=0x1234 -> ex_read_data1=ex_read_data2=0x1234.
  - With wb_write_reg=0 -> both operands keep 0xAAAA.
- Saturation and reset mid-stream: force 65536 stalls -> stall_count holds 0xFFFF; then assert rst=0 during a stall -> next posedge all outputs are 0 and stall_out=0 while reset is held.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: load-use stall with bubble insert, branch flush, same-edge WB bypass.
// Latency 1 cycle; backpressure is stall_out (holds upstream), flush overrides stall.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      id_read_data1,
    input  logic [31:0]      id_read_data2,
    input  logic [31:0]      id_imm,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rt,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             id_alu_src,
    input  logic             id_reg_dst,
    input  logic [3:0]       id_alu_op,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_write_reg,
    input  logic [31:0]      wb_write_data,
    input  logic             flush,
    output logic             stall_out,
    output logic             ex_valid,
    output logic [31:0]      ex_pc,
    output logic [31:0]      ex_read_data1,
    output logic [31:0]      ex_read_data2,
    output logic [31:0]      ex_imm,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic [4:0]       ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             ex_alu_src,
    output logic             ex_reg_dst,
    output logic [3:0]       ex_alu_op,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        alu_src;
        logic        reg_dst;
        logic [3:0]  alu_op;
    } ex_reg_t;

    ex_reg_t          r_ex;
    ex_reg_t          w_load;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_hazard;
    logic             w_rs_byp;
    logic             w_rt_byp;

    // The register file reads on negedge, so a write landing on this edge is not yet visible.
    assign w_rs_byp = wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == id_rs);
    assign w_rt_byp = wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == id_rt);

    always_comb begin
        w_load            = '0;
        w_load.valid      = id_valid;
        w_load.pc         = id_pc;
        w_load.rd1        = w_rs_byp ? wb_write_data : id_read_data1;
        w_load.rd2        = w_rt_byp ? wb_write_data : id_read_data2;
        w_load.imm        = id_imm;
        w_load.rs         = id_rs;
        w_load.rt         = id_rt;
        w_load.rd         = id_rd;
        w_load.reg_write  = id_valid & id_reg_write;
        w_load.mem_read   = id_valid & id_mem_read;
        w_load.mem_write  = id_valid & id_mem_write;
        w_load.mem_to_reg = id_valid & id_mem_to_reg;
        w_load.alu_src    = id_valid & id_alu_src;
        w_load.reg_dst    = id_valid & id_reg_dst;
        w_load.alu_op     = id_valid ? id_alu_op : 4'd0;
    end

    assign w_hazard = id_valid & r_ex.valid & r_ex.mem_read & (r_ex.rt != 5'd0)
                    & ((r_ex.rt == id_rs) | (id_uses_rt & (r_ex.rt == id_rt)));

    assign stall_out = w_hazard & ~flush & rst;

    // The bubble clears mem_read, so each load-use pair costs exactly one stall cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ex        <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (flush) begin
            r_ex <= '0;
            if (r_flush_cnt != '1) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end else if (w_hazard) begin
            r_ex <= '0;
            if (r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
        end else begin
            r_ex <= w_load;
        end
    end

    assign ex_valid      = r_ex.valid;
    assign ex_pc         = r_ex.pc;
    assign ex_read_data1 = r_ex.rd1;
    assign ex_read_data2 = r_ex.rd2;
    assign ex_imm        = r_ex.imm;
    assign ex_rs         = r_ex.rs;
    assign ex_rt         = r_ex.rt;
    assign ex_rd         = r_ex.rd;
    assign ex_reg_write  = r_ex.reg_write;
    assign ex_mem_read   = r_ex.mem_read;
    assign ex_mem_write  = r_ex.mem_write;
    assign ex_mem_to_reg = r_ex.mem_to_reg;
    assign ex_alu_src    = r_ex.alu_src;
    assign ex_reg_dst    = r_ex.reg_dst;
    assign ex_alu_op     = r_ex.alu_op;
    assign stall_count   = r_stall_cnt;
    assign flush_count   = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage with a queue-based scoreboard.
module tb_id_ex_stage;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        bit        rst;
        bit        valid;
        bit [31:0] pc, rd1, rd2, imm;
        bit [4:0]  rs, rt, rd;
        bit        uses_rt, reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst;
        bit [3:0]  alu_op;
        bit        wb_we;
        bit [4:0]  wb_reg;
        bit [31:0] wb_data;
        bit        flush;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
        logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst;
        logic [3:0]  alu_op;
    } exp_t;

    typedef struct {
        bit   stall;
        exp_t ex;
        int   scnt;
        int   fcnt;
    } item_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid, id_uses_rt, id_reg_write, id_mem_read, id_mem_write;
    logic             id_mem_to_reg, id_alu_src, id_reg_dst;
    logic [31:0]      id_pc, id_read_data1, id_read_data2, id_imm;
    logic [4:0]       id_rs, id_rt, id_rd;
    logic [3:0]       id_alu_op;
    logic             wb_reg_write;
    logic [4:0]       wb_write_reg;
    logic [31:0]      wb_write_data;
    logic             flush;
    logic             stall_out, ex_valid;
    logic [31:0]      ex_pc, ex_read_data1, ex_read_data2, ex_imm;
    logic [4:0]       ex_rs, ex_rt, ex_rd;
    logic             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst;
    logic [3:0]       ex_alu_op;
    logic [CNT_W-1:0] stall_count, flush_count;

    id_ex_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_read_data1(id_read_data1), .id_read_data2(id_read_data2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_alu_op(id_alu_op), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data), .flush(flush), .stall_out(stall_out),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_read_data1(ex_read_data1),
        .ex_read_data2(ex_read_data2), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src),
        .ex_reg_dst(ex_reg_dst), .ex_alu_op(ex_alu_op), .stall_count(stall_count),
        .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    item_t q_exp[$];
    int    total   = 0;
    int    bad     = 0;
    int    pushed  = 0;
    int    popped  = 0;
    exp_t  m_ex    = '0;
    int    m_scnt  = 0;
    int    m_fcnt  = 0;
    stim_t prev;

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic stim_t load_word(input bit [4:0] rt);
        stim_t s = idle();
        s.valid = 1; s.mem_read = 1; s.mem_to_reg = 1; s.reg_write = 1; s.alu_src = 1;
        s.rs = 5'd1; s.rt = rt; s.pc = 32'h100; s.imm = 32'h4;
        return s;
    endfunction

    function automatic stim_t alu_op_rr(input bit [4:0] rs, input bit [4:0] rt);
        stim_t s = idle();
        s.valid = 1; s.uses_rt = 1; s.reg_write = 1; s.reg_dst = 1; s.alu_op = 4'd2;
        s.rs = rs; s.rt = rt; s.rd = 5'd9; s.pc = 32'h104;
        s.rd1 = 32'h5555; s.rd2 = 32'h6666;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst        = ($urandom_range(0, 99) != 0);
        s.valid      = ($urandom_range(0, 99) < 85);
        s.pc         = $urandom; s.rd1 = $urandom; s.rd2 = $urandom; s.imm = $urandom;
        s.rs         = 5'($urandom_range(0, 7));
        s.rt         = 5'($urandom_range(0, 7));
        s.rd         = 5'($urandom_range(0, 31));
        s.uses_rt    = 1'($urandom); s.reg_write = 1'($urandom);
        s.mem_read   = ($urandom_range(0, 99) < 35);
        s.mem_write  = 1'($urandom); s.mem_to_reg = 1'($urandom);
        s.alu_src    = 1'($urandom); s.reg_dst = 1'($urandom);
        s.alu_op     = 4'($urandom);
        s.wb_we      = 1'($urandom);
        s.wb_reg     = 5'($urandom_range(0, 7));
        s.wb_data    = $urandom;
        s.flush      = ($urandom_range(0, 99) < 8);
        return s;
    endfunction

    // Load-use: the instruction in EX is a real load whose nonzero target the decode instruction reads.
    function automatic bit load_use(input exp_t e, input stim_t s);
        bit reads_it;
        reads_it = (e.rt == s.rs) || (s.uses_rt && (e.rt == s.rt));
        return s.valid && e.valid && e.mem_read && (e.rt != 0) && reads_it;
    endfunction

    function automatic exp_t captured(input stim_t s);
        exp_t e = '0;
        e.valid = s.valid; e.pc = s.pc; e.imm = s.imm;
        e.rs = s.rs; e.rt = s.rt; e.rd = s.rd;
        e.rd1 = (s.wb_we && s.wb_reg != 0 && s.wb_reg == s.rs) ? s.wb_data : s.rd1;
        e.rd2 = (s.wb_we && s.wb_reg != 0 && s.wb_reg == s.rt) ? s.wb_data : s.rd2;
        if (s.valid) begin
            e.reg_write = s.reg_write; e.mem_read = s.mem_read; e.mem_write = s.mem_write;
            e.mem_to_reg = s.mem_to_reg; e.alu_src = s.alu_src; e.reg_dst = s.reg_dst;
            e.alu_op = s.alu_op;
        end
        return e;
    endfunction

    task automatic advance_model(input stim_t s);
        if (!s.rst) begin
            m_ex = '0; m_scnt = 0; m_fcnt = 0;
        end else if (s.flush) begin
            m_ex = '0;
            if (m_fcnt < CNT_MAX) m_fcnt++;
        end else if (load_use(m_ex, s)) begin
            m_ex = '0;
            if (m_scnt < CNT_MAX) m_scnt++;
        end else begin
            m_ex = captured(s);
        end
    endtask

    task automatic apply(input stim_t s);
        rst = s.rst; id_valid = s.valid; id_pc = s.pc;
        id_read_data1 = s.rd1; id_read_data2 = s.rd2; id_imm = s.imm;
        id_rs = s.rs; id_rt = s.rt; id_rd = s.rd; id_uses_rt = s.uses_rt;
        id_reg_write = s.reg_write; id_mem_read = s.mem_read; id_mem_write = s.mem_write;
        id_mem_to_reg = s.mem_to_reg; id_alu_src = s.alu_src; id_reg_dst = s.reg_dst;
        id_alu_op = s.alu_op; wb_reg_write = s.wb_we; wb_write_reg = s.wb_reg;
        wb_write_data = s.wb_data; flush = s.flush;
    endtask

    // Each call owns one cycle: the model steps over the edge just taken, then new inputs go out.
    task automatic drive(input stim_t s);
        item_t it;
        @(posedge clk);
        #2;
        advance_model(prev);
        apply(s);
        it.stall = load_use(m_ex, s) && !s.flush && s.rst;
        it.ex    = m_ex;
        it.scnt  = m_scnt;
        it.fcnt  = m_fcnt;
        q_exp.push_back(it);
        pushed++;
        prev = s;
    endtask

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        item_t it;
        exp_t  act;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                it = q_exp.pop_front();
                popped++;
                act.valid = ex_valid; act.pc = ex_pc; act.rd1 = ex_read_data1;
                act.rd2 = ex_read_data2; act.imm = ex_imm; act.rs = ex_rs; act.rt = ex_rt;
                act.rd = ex_rd; act.reg_write = ex_reg_write; act.mem_read = ex_mem_read;
                act.mem_write = ex_mem_write; act.mem_to_reg = ex_mem_to_reg;
                act.alu_src = ex_alu_src; act.reg_dst = ex_reg_dst; act.alu_op = ex_alu_op;
                check("stall_out", 200'(stall_out), 200'(it.stall));
                check("ex_regs", 200'(act), 200'(it.ex));
                check("stall_count", 200'(stall_count), 200'(it.scnt));
                check("flush_count", 200'(flush_count), 200'(it.fcnt));
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        prev = rand_stim();
        prev.rst = 0;
        apply(prev);

        // Reset held with busy decode inputs.
        s = rand_stim(); s.rst = 0; s.valid = 1; s.mem_read = 1; drive(s);
        s = rand_stim(); s.rst = 0; s.valid = 1; drive(s);

        // Plain capture.
        s = idle(); s.valid = 1; s.rd1 = 32'h11; s.rd2 = 32'h22; s.imm = 32'hFFFF_FFF0;
        s.rs = 1; s.rt = 2; s.rd = 3; s.reg_write = 1; s.alu_op = 4'd2; drive(s);

        // Load-use on rs: one stall, then the held instruction enters EX.
        drive(load_word(5'd5));
        drive(alu_op_rr(5'd5, 5'd6));
        drive(alu_op_rr(5'd5, 5'd6));
        drive(idle());

        // No stall: load target r0, and rt match without rt use.
        drive(load_word(5'd0));
        drive(alu_op_rr(5'd0, 5'd0));
        drive(load_word(5'd5));
        s = alu_op_rr(5'd1, 5'd5); s.uses_rt = 0; drive(s);
        drive(load_word(5'd6));
        drive(alu_op_rr(5'd2, 5'd6));

        // Flush wins over a simultaneous load-use hazard.
        drive(load_word(5'd5));
        s = alu_op_rr(5'd5, 5'd5); s.flush = 1; drive(s);
        drive(idle());

        // Write-back bypass on both operands, then suppressed for r0.
        s = alu_op_rr(5'd7, 5'd7); s.rd1 = 32'hAAAA; s.rd2 = 32'hAAAA;
        s.wb_we = 1; s.wb_reg = 5'd7; s.wb_data = 32'h1234; drive(s);
        s.rs = 0; s.rt = 0; s.wb_reg = 5'd0; drive(s);
        s.rs = 7; s.rt = 3; s.wb_reg = 5'd3; drive(s);

        // Drive both counters into saturation.
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            drive(load_word(5'd5));
            drive(alu_op_rr(5'd5, 5'd1));
        end
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            s = rand_stim(); s.rst = 1; s.flush = 1; drive(s);
        end

        // Reset asserted while a stall is pending, and held for two cycles.
        drive(load_word(5'd5));
        s = alu_op_rr(5'd5, 5'd1); s.rst = 0; drive(s);
        drive(s);
        drive(idle());

        for (int i = 0; i < 3000; i++) begin
            drive(rand_stim());
        end
        drive(idle());

        @(negedge clk);
        #1;
        total++;
        if (popped != pushed || q_exp.size() != 0) begin
            bad++;
            $display("FAIL drain: got popped=%0d want %0d", popped, pushed);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
